fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter sequencer for the instruction ROM. Holds the PC, drives it
//  to the ROM's PC input, and takes back the ROM's combinational inst output.
//  Qualifies each fetched word as an issued instruction.
//  Applies absolute/relative branches, stalls and halt detection.
//  Keeps cycle and instruction counters for program benchmarking.
// PARAMETERS
//  PC_W       16        PC / branch address width
//  IW         9         instruction width
//  HALT_OP    9'h1FF    opcode that ends the program (111_111_111)
//  START_ADDR 0         PC value loaded on reset and on each start
//  CNT_W      16        width of cycle_cnt / inst_cnt
// PORTS
//  CLK         in   1      single clock, all state updates on rising edge
//  reset_n     in   1      synchronous, active-low reset
//  start       in   1      begin execution (sampled in IDLE/HALT only)
//  stall       in   1      hold PC this cycle (datapath busy)
//  br_abs_en   in   1      take absolute branch to br_target
//  br_target   in   PC_W   absolute branch address
//  br_rel_en   in   1      take relative branch PC + br_offset
//  br_offset   in   PC_W   signed two's-complement offset
//  inst_in     in   IW     word from ROM at address PC (same cycle)
//  PC          out  PC_W   address to ROM
//  inst_out    out  IW     issued instruction (inst_in when inst_valid, else 0)
//  inst_valid  out  1      inst_out is issued this cycle
//  busy        out  1      state==RUN
//  halted      out  1      state==HALT
//  cycle_cnt   out  CNT_W  cycles spent in RUN since last start
//  inst_cnt    out  CNT_W  instructions issued since last start (incl. halt)
// BEHAVIOUR
//  States: IDLE -> RUN -> HALT -> RUN (via start). Encoding is free.
//  Reset (reset_n=0 at edge, any state):
//   - state=IDLE, PC=START_ADDR, counters=0.
//   - Outputs are then inst_valid=0, busy=0, halted=0 and inst_out=0.
//   - Mid-RUN reset discards any pending branch.
//  IDLE/HALT:
//   - PC held. start=1 -> next state RUN, PC=START_ADDR, counters cleared.
//   - Branch and stall inputs are ignored.
//  RUN:
//   - inst_valid = !stall (combinational).
//   - inst_out = inst_in gated by inst_valid.
//   - start is ignored.
//  RUN next-PC priority (only when stall=0):
//   1. inst_in==HALT_OP -> state HALT, PC held at the halt address.
//      Branch inputs are ignored in this cycle.
//   2. br_abs_en -> PC=br_target (wins if both branch enables are high).
//   3. br_rel_en -> PC=PC+br_offset, mod 2^PC_W.
//   4. else PC=PC+1, wrapping 2^PC_W-1 -> 0.
//  RUN with stall=1:
//   - PC, state and branch inputs are ignored/held.
//   - A branch must be re-presented once stall drops.
//   - A halt under stall is not taken until stall=0.
//  Latency:
//   - Branch taken at edge N -> ROM addressed at target in cycle N+1.
//   - No delay slot; issue rate is 1 instruction/cycle.
//  Counters:
//   - cycle_cnt +1 every RUN cycle, stalled or not.
//   - inst_cnt +1 every cycle with inst_valid=1.
//   - Both saturate at all-ones, never wrap.
//   - Both are frozen in IDLE/HALT and readable until the next start.
// TESTING
//  T1 reset then start; ROM holds 3 NOPs then 9'h1FF at 3:
//     PC 0,1,2,3; halted=1 the cycle after PC=3; inst_cnt=4, cycle_cnt=4.
//  T2 br_abs_en=1, br_target=8 at PC=2, also br_rel_en=1:
//     next PC=8 (abs wins); then 9, 10.
//  T3 br_rel_en=1, br_offset=16'hFFFD at PC=7:
//     next PC=4. Separately, PC=16'hFFFF with no branch: next PC=0.
//  T4 stall=1 for 2 cycles at PC=5 with br_abs_en pulse during stall:
//     PC stays 5, inst_valid=0, cycle_cnt +2, inst_cnt +0; then PC=6.
//  T5 reset_n=0 for 1 cycle mid-RUN at PC=9:
//     PC=0, IDLE, counters 0. start ignored while RUN; start in HALT restarts at 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM.
// Drives PC to the ROM, qualifies the returned word as an issued instruction,
// applies absolute/relative branches, stalls and halt detection, and keeps
// saturating cycle/instruction counters for benchmarking.
module fetch_sequencer #(
    parameter int                PC_W       = 16,
    parameter int                IW         = 9,
    parameter logic [IW-1:0]     HALT_OP    = 9'h1FF,
    parameter logic [PC_W-1:0]   START_ADDR = 16'h0000,
    parameter int                CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stall,
    input  logic              br_abs_en,
    input  logic [PC_W-1:0]   br_target,
    input  logic              br_rel_en,
    input  logic [PC_W-1:0]   br_offset,
    input  logic [IW-1:0]     inst_in,
    output logic [PC_W-1:0]   PC,
    output logic [IW-1:0]     inst_out,
    output logic              inst_valid,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   inst_cnt_q, inst_cnt_d;
    logic               inst_valid_s;

    // Counters stick at all-ones so a long benchmark never reads back as short.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state, next-PC and counter update; defaults hold every register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cycle_cnt_d  = cycle_cnt_q;
        inst_cnt_d   = inst_cnt_q;
        inst_valid_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                // Branch and stall inputs have no effect outside RUN.
                if (start) begin
                    state_d     = ST_RUN;
                    pc_d        = START_ADDR;
                    cycle_cnt_d = {CNT_W{1'b0}};
                    inst_cnt_d  = {CNT_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                inst_valid_s = ~stall;
                cycle_cnt_d  = sat_inc(cycle_cnt_q);
                if (!stall) begin
                    inst_cnt_d = sat_inc(inst_cnt_q);
                    // Halt outranks any branch presented alongside it.
                    if (inst_in == HALT_OP) begin
                        state_d = ST_HALT;
                    end else if (br_abs_en) begin
                        pc_d = br_target;
                    end else if (br_rel_en) begin
                        pc_d = pc_q + br_offset;
                    end else begin
                        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    // Stalled: PC and state hold; a branch must be re-presented.
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pc_d        = START_ADDR;
                cycle_cnt_d = {CNT_W{1'b0}};
                inst_cnt_d  = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, PC and counter registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= START_ADDR;
            cycle_cnt_q <= {CNT_W{1'b0}};
            inst_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    // The ROM word is issued in the same cycle it is addressed.
    always_comb begin
        inst_valid = inst_valid_s;
        if (inst_valid_s) begin
            inst_out = inst_in;
        end else begin
            inst_out = {IW{1'b0}};
        end
    end

    assign PC        = pc_q;
    assign busy      = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALT);
    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a cycle-level behavioural model
// compared on every falling edge, plus hand-computed literal checkpoints.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        reset_n, start, stall, br_abs_en, br_rel_en;
    logic [15:0] br_target, br_offset;
    logic [8:0]  inst_in;
    logic [15:0] PC;
    logic [8:0]  inst_out;
    logic        inst_valid, busy, halted;
    logic [15:0] cycle_cnt, inst_cnt;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .CLK(CLK), .reset_n(reset_n), .start(start), .stall(stall),
        .br_abs_en(br_abs_en), .br_target(br_target),
        .br_rel_en(br_rel_en), .br_offset(br_offset),
        .inst_in(inst_in), .PC(PC), .inst_out(inst_out),
        .inst_valid(inst_valid), .busy(busy), .halted(halted),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );

    always #5 CLK = ~CLK;

    // ROM image: halt opcode at address 3, recognisable non-halt words elsewhere.
    always_comb begin
        if (PC == 16'd3) inst_in = 9'h1FF;
        else             inst_in = PC[8:0] ^ 9'h0A5;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0=idle, 1=run, 2=halt.
    int m_state = 0, m_pc = 0, m_cc = 0, m_ic = 0;
    bit m_known = 1'b0;

    // Compare the DUT with the model mid-cycle, then advance the model past the next edge.
    always @(negedge CLK) begin
        if (m_known) begin
            automatic bit exp_valid = (m_state == 1) && !stall;
            chk("pc", {16'h0, PC}, m_pc);
            chk("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
            chk("inst_out", {23'h0, inst_out}, exp_valid ? {23'h0, inst_in} : 32'h0);
            chk("busy", {31'h0, busy}, (m_state == 1) ? 32'h1 : 32'h0);
            chk("halted", {31'h0, halted}, (m_state == 2) ? 32'h1 : 32'h0);
            chk("cycle_cnt", {16'h0, cycle_cnt}, m_cc);
            chk("inst_cnt", {16'h0, inst_cnt}, m_ic);
        end
        if (!reset_n) begin
            m_state = 0; m_pc = 0; m_cc = 0; m_ic = 0; m_known = 1'b1;
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_pc = 0; m_cc = 0; m_ic = 0;
            end
        end else begin
            m_cc = (m_cc < 65535) ? m_cc + 1 : 65535;
            if (!stall) begin
                m_ic = (m_ic < 65535) ? m_ic + 1 : 65535;
                if (inst_in == 9'h1FF)   m_state = 2;
                else if (br_abs_en)      m_pc = br_target;
                else if (br_rel_en)      m_pc = (m_pc + int'(br_offset)) % 65536;
                else                     m_pc = (m_pc + 1) % 65536;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string name, input int pc_e, input int busy_e,
                       input int halt_e, input int cc_e, input int ic_e);
        chk({name, "_pc"}, {16'h0, PC}, pc_e);
        chk({name, "_busy"}, {31'h0, busy}, busy_e);
        chk({name, "_halted"}, {31'h0, halted}, halt_e);
        chk({name, "_cc"}, {16'h0, cycle_cnt}, cc_e);
        chk({name, "_ic"}, {16'h0, inst_cnt}, ic_e);
    endtask

    task automatic clr_br();
        br_abs_en = 1'b0; br_rel_en = 1'b0; br_target = 16'h0; br_offset = 16'h0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stall = 1'b0; clr_br();
        tick(); tick();
        reset_n = 1'b1;
        lit("reset", 0, 0, 0, 0, 0);
        #1 chk("reset_valid", {31'h0, inst_valid}, 32'h0);
        chk("reset_out", {23'h0, inst_out}, 32'h0);

        // Branch in IDLE is ignored.
        br_abs_en = 1'b1; br_target = 16'd20;
        tick(); clr_br();
        lit("idle_br", 0, 0, 0, 0, 0);

        // T1: run to the halt at address 3.
        start = 1'b1; tick(); start = 1'b0;
        lit("t1_start", 0, 1, 0, 0, 0);
        tick(); tick(); tick();
        lit("t1_pc3", 3, 1, 0, 3, 3);
        #1 chk("t1_halt_valid", {31'h0, inst_valid}, 32'h1);
        chk("t1_halt_out", {23'h0, inst_out}, 32'h1FF);
        br_abs_en = 1'b1; br_target = 16'd20;   // ignored in the halt cycle
        tick(); clr_br();
        lit("t1_halted", 3, 0, 1, 4, 4);
        tick();
        lit("t1_frozen", 3, 0, 1, 4, 4);

        // T2: both branch enables, absolute wins.
        start = 1'b1; tick(); start = 1'b0;
        lit("t2_restart", 0, 1, 0, 0, 0);
        tick(); tick();
        br_abs_en = 1'b1; br_target = 16'd8; br_rel_en = 1'b1; br_offset = 16'h0010;
        tick(); clr_br();
        lit("t2_abs", 8, 1, 0, 3, 3);
        tick(); tick();
        lit("t2_seq", 10, 1, 0, 5, 5);

        // T3: relative backwards branch 7 + (-3) = 4.
        br_abs_en = 1'b1; br_target = 16'd7;
        tick(); clr_br();
        br_rel_en = 1'b1; br_offset = 16'hFFFD;
        tick(); clr_br();
        lit("t3_rel", 4, 1, 0, 7, 7);
        tick();

        // T4: two stalled cycles at PC=5 with a branch pulse that must be dropped.
        stall = 1'b1; br_abs_en = 1'b1; br_target = 16'd20;
        #1 chk("t4_valid", {31'h0, inst_valid}, 32'h0);
        chk("t4_out", {23'h0, inst_out}, 32'h0);
        tick(); clr_br();
        tick();
        lit("t4_stalled", 5, 1, 0, 10, 8);
        stall = 1'b0;
        tick();
        lit("t4_resume", 6, 1, 0, 11, 9);

        // PC wrap from all-ones to zero.
        br_abs_en = 1'b1; br_target = 16'hFFFF;
        tick(); clr_br();
        tick();
        lit("wrap", 0, 1, 0, 13, 11);
        tick(); tick(); tick();
        // Halt presented under stall is deferred.
        stall = 1'b1;
        tick();
        lit("halt_stall", 3, 1, 0, 17, 14);
        stall = 1'b0;
        tick();
        lit("halt_late", 3, 0, 1, 18, 15);

        // T5: reset mid-RUN, then start ignored in RUN, restart from HALT.
        start = 1'b1; tick(); start = 1'b0;
        br_abs_en = 1'b1; br_target = 16'd9;
        tick(); clr_br();
        lit("t5_pc9", 9, 1, 0, 1, 1);
        reset_n = 1'b0; br_rel_en = 1'b1; br_offset = 16'h0004;
        tick(); clr_br(); reset_n = 1'b1;
        lit("t5_reset", 0, 0, 0, 0, 0);
        start = 1'b1; tick();
        tick(); tick();
        lit("t5_start_ign", 2, 1, 0, 2, 2);
        start = 1'b0;
        tick(); tick();
        lit("t5_halt", 3, 0, 1, 4, 4);
        start = 1'b1; tick(); start = 1'b0;
        lit("t5_restart", 0, 1, 0, 0, 0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
